arb_requester: RTL
==================

Name: arb_requester

Overview:
- Requester-side companion to the 4-way fixed-priority req/gnt arbiter; one instance drives all requesting channels.
- Accepts per-channel burst commands, raises and holds req for the burst, and counts granted beats.
- Tolerates preemption by higher-priority channels and masks the trailing grant that follows req deassertion. The arbiter registers its grant, so gnt lags req by one cycle.
- Flags starvation and protocol errors.

Parameters:
N, 4, number of channels (matches arbiter width)
LEN_W, 4, burst length width; legal lengths 1..2^LEN_W-1
STARVE_LIMIT, 16, ACTIVE cycles without a beat before starve[i] asserts
WAIT_W, 8, width of per-channel wait counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  N  per-channel burst command strobe, sampled on clk
len  in  N*LEN_W  burst length; channel i uses len[i*LEN_W +: LEN_W]
busy  out  N  channel not IDLE
req  out  N  request to arbiter, registered
gnt  in  N  grant from arbiter, one-hot or zero
beat  out  N  one beat transferred this cycle
done  out  N  one-cycle pulse, burst complete
starve  out  N  channel waiting longer than STARVE_LIMIT
err_gnt  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0):
  - All channels go to IDLE.
  - req, beat, done, starve, busy, err_gnt all 0; counters cleared.
  - Reset mid-burst abandons the burst with no done pulse.
- Per-channel FSM: IDLE -> ACTIVE -> DRAIN -> IDLE.
- IDLE:
  - start[i]=1 with len!=0: latch len into rem[i], go to ACTIVE.
  - start with len=0: ignored.
  - start in ACTIVE or DRAIN: ignored; the latched burst is unaffected.
- ACTIVE:
  - req[i]=1 (a registered decode of state), busy[i]=1.
  - beat[i] = gnt[i] (combinational from gnt, qualified by state==ACTIVE).
  - Each beat decrements rem[i].
  - A beat with rem[i]==1 moves the channel to DRAIN.
- Preemption: if gnt moves to another channel, beats pause. rem[i] is held and req[i] stays 1. Beats resume when the grant returns. Total beats always equal the latched len.
- DRAIN (exactly 1 cycle):
  - req[i]=0, done[i]=1, busy[i]=1.
  - gnt[i]=1 here is the expected trailing grant: no beat, no error.
  - Next state is IDLE.
- Latency for an uncontended channel:
  - start sampled in cycle 0 -> req in c1 -> first beat in c2.
  - Last beat in c(len+1); done in c(len+2); busy low in c(len+3).
- Back-to-back bursts: the minimum gap between bursts on one channel is DRAIN plus IDLE. A new start is accepted in the cycle busy is 0.
- Starvation:
  - wait[i] increments each ACTIVE cycle with gnt[i]=0 and saturates at 2^WAIT_W-1.
  - wait[i] clears on beat and on leaving ACTIVE.
  - starve[i] = (state==ACTIVE && wait[i] >= STARVE_LIMIT), registered.
- err_gnt is set on either of these, and clears only on reset:
  - more than one gnt bit set;
  - gnt[i]=1 while channel i is in IDLE.
- Simultaneous events: start on several channels in the same cycle is accepted independently on each. Each channel's FSM is independent and ordering is decided solely by the arbiter.

Test Plan:
- Single burst: ch0 start, len=3, in c0; bench arbiter model grants.
  -> req[0]=1 in c1..c4; beat[0]=1 in c2,c3,c4; done[0] in c5 with gnt[0]=1 still present and no beat, no err; busy[0]=0 in c6.
- Preemption: ch2 len=4 active and beating; ch0 start len=2 mid-burst.
  -> ch2 beats pause while ch0 is granted; ch0 gets exactly 2 beats and done; ch2 then gets its remaining beats for exactly 4 total; req[2] stays high throughout.
- Starvation with STARVE_LIMIT=4: ch0 len=15 and ch3 len=1 started together.
  -> starve[3]=1 from the 5th waiting cycle until ch3's beat after ch0 DRAIN, then 0; starve[0] never asserts.
- Ignored commands:
  - start[1] with len=0 -> no busy, no req;
  - start[1] len=5 while ch1 ACTIVE with len=2 -> exactly 2 beats.
- Protocol errors:
  - drive gnt=4'b0011 -> err_gnt=1 and stays 1;
  - after reset, gnt[1]=1 with ch1 IDLE -> err_gnt=1;
  - trailing gnt in DRAIN -> err_gnt stays 0.
- Reset mid-burst: assert rst_n=0 asynchronously while ch2 ACTIVE with rem=3.
  -> req, busy, beat, starve go 0 immediately; no done; a fresh start after release runs the full length.

Source files
------------

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - per-channel burst requester for a fixed-priority registered-grant arbiter
module arb_requester #(
    parameter int N            = 4,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int WAIT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       start,
    input  logic [N*LEN_W-1:0] len,
    output logic [N-1:0]       busy,
    output logic [N-1:0]       req,
    input  logic [N-1:0]       gnt,
    output logic [N-1:0]       beat,
    output logic [N-1:0]       done,
    output logic [N-1:0]       starve,
    output logic               err_gnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [N-1:0]      GNT_ONE   = N'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

    state_t            state_q [N];
    state_t            state_d [N];
    logic [LEN_W-1:0]  rem_q   [N];
    logic [LEN_W-1:0]  rem_d   [N];
    logic [WAIT_W-1:0] wait_q  [N];
    logic [WAIT_W-1:0] wait_d  [N];
    logic [N-1:0]      req_q, req_d;
    logic [N-1:0]      busy_q, busy_d;
    logic [N-1:0]      done_q, done_d;
    logic [N-1:0]      starve_q, starve_d;
    logic              err_q, err_d;

    // The trailing grant seen in DRAIN is legal because the arbiter registers gnt one cycle behind req.
    always_comb begin
        err_d    = err_q;
        beat     = '0;
        req_d    = '0;
        busy_d   = '0;
        done_d   = '0;
        starve_d = '0;
        if ((gnt & (gnt - GNT_ONE)) != '0) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            wait_d[i]  = '0;
            case (state_q[i])
                ST_IDLE: begin
                    if (gnt[i]) begin
                        err_d = 1'b1;
                    end
                    if (start[i] && (len[i*LEN_W +: LEN_W] != '0)) begin
                        rem_d[i]   = len[i*LEN_W +: LEN_W];
                        state_d[i] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (gnt[i]) begin
                        beat[i]  = 1'b1;
                        rem_d[i] = rem_q[i] - LEN_ONE;
                        if (rem_q[i] == LEN_ONE) begin
                            state_d[i] = ST_DRAIN;
                        end
                    end else if (wait_q[i] != WAIT_MAX) begin
                        wait_d[i] = wait_q[i] + 1'b1;
                    end else begin
                        wait_d[i] = wait_q[i];
                    end
                end
                ST_DRAIN: state_d[i] = ST_IDLE;
                default:  state_d[i] = ST_IDLE;
            endcase
            req_d[i]    = (state_d[i] == ST_ACTIVE);
            busy_d[i]   = (state_d[i] != ST_IDLE);
            done_d[i]   = (state_d[i] == ST_DRAIN);
            starve_d[i] = (state_d[i] == ST_ACTIVE) && (wait_d[i] >= STARVE_TH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_IDLE;
                rem_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
            req_q    <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
                wait_q[i]  <= wait_d[i];
            end
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    assign req     = req_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign starve  = starve_q;
    assign err_gnt = err_q;

endmodule
